// File: rtl/spi_plock_cfg_seq.sv
// spi_plock_cfg_seq: replays a table of timed register writes and SPI pulses into a register bank
module spi_plock_cfg_seq #(
  parameter int NREG = 16,
  parameter int REGW = 16,
  parameter int DEPTH = 32,
  parameter int WAITW = 16,
  parameter int PULSEW = 8,
  localparam int IW = $clog2(NREG),
  localparam int AW = $clog2(DEPTH),
  localparam int EW = 2 + IW + REGW + WAITW
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 CFG_WE,
  input  logic [AW-1:0]        CFG_WADDR,
  input  logic [EW-1:0]        CFG_WDATA,
  input  logic                 START,
  input  logic                 ABORT,
  input  logic                 LOOP_EN,
  input  logic [AW-1:0]        LOOP_IDX,
  input  logic [PULSEW-1:0]    PULSE_LEN,
  output logic [NREG*REGW-1:0] REG_OUT,
  output logic                 SPI_NARST,
  output logic                 SPI_CONFIG,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [AW-1:0]        CUR_IDX,
  output logic                 WR_COLL
);
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_PULSE, S_WAIT} state_t;
  state_t st;
  logic [EW-1:0] tbl [DEPTH];
  logic [EW-1:0] ent;
  logic [PULSEW-1:0] pcnt, plen;
  logic [WAITW-1:0] wcnt, wt;
  logic [1:0] op;
  logic [IW-1:0] idx;
  logic [REGW-1:0] val;
  logic is_end, step_done, adv, fin;
  always_comb begin
    op = ent[EW-1 -: 2];
    idx = ent[WAITW+REGW +: IW];
    val = ent[WAITW +: REGW];
    wt = ent[WAITW-1:0];
    plen = PULSE_LEN == '0 ? PULSEW'(1) : PULSE_LEN;
    is_end = st == S_EXEC && op == 2'd3;
    step_done = (st == S_EXEC && op == 2'd0 && wt == '0) ||
                (st == S_PULSE && pcnt == PULSEW'(1) && wt == '0) ||
                (st == S_WAIT && wcnt == WAITW'(1));
    adv = step_done || is_end;
    // the last table slot behaves as END once its own step completes
    fin = is_end || (step_done && CUR_IDX == AW'(DEPTH - 1));
  end
  always_ff @(posedge CLK)
    if (CFG_WE && !BUSY) tbl[CFG_WADDR] <= CFG_WDATA;
  always_ff @(posedge CLK) begin
    if (RST) begin
      st <= S_IDLE;
      ent <= '0;
      pcnt <= '0;
      wcnt <= '0;
      REG_OUT <= '0;
      SPI_NARST <= 1'b1;
      SPI_CONFIG <= 1'b0;
      BUSY <= 1'b0;
      DONE <= 1'b0;
      CUR_IDX <= '0;
      WR_COLL <= 1'b0;
    end else begin
      if (CFG_WE && BUSY) WR_COLL <= 1'b1;
      if (ABORT) begin
        st <= S_IDLE;
        SPI_NARST <= 1'b1;
        SPI_CONFIG <= 1'b0;
        BUSY <= 1'b0;
        CUR_IDX <= '0;
      end else begin
        case (st)
          S_IDLE: if (START) begin
            st <= S_FETCH;
            BUSY <= 1'b1;
            DONE <= 1'b0;
            CUR_IDX <= '0;
          end
          S_FETCH: begin
            ent <= tbl[CUR_IDX];
            st <= S_EXEC;
          end
          S_EXEC: if (op == 2'd1 || op == 2'd2) begin
            SPI_NARST <= op != 2'd1;
            SPI_CONFIG <= op == 2'd2;
            pcnt <= plen;
            st <= S_PULSE;
          end else if (op == 2'd0) begin
            wcnt <= wt;
            st <= S_WAIT;
          end
          S_PULSE: if (pcnt == PULSEW'(1)) begin
            SPI_NARST <= 1'b1;
            SPI_CONFIG <= 1'b0;
            wcnt <= wt;
            st <= S_WAIT;
          end else pcnt <= pcnt - 1'b1;
          S_WAIT: wcnt <= wcnt - 1'b1;
          default: st <= S_IDLE;
        endcase
        // an out-of-range IDX matches no register, so the write is dropped
        for (int k = 0; k < NREG; k++)
          if (st == S_EXEC && op == 2'd0 && idx == IW'(k)) REG_OUT[k*REGW +: REGW] <= val;
        if (adv) begin
          st <= (fin && !LOOP_EN) ? S_IDLE : S_FETCH;
          CUR_IDX <= !fin ? CUR_IDX + 1'b1 : LOOP_EN ? LOOP_IDX : '0;
          if (fin && !LOOP_EN) begin
            BUSY <= 1'b0;
            DONE <= 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_spi_plock_cfg_seq.sv
// tb_spi_plock_cfg_seq: checks replay timing against a step-cost schedule model of the table
module tb_spi_plock_cfg_seq;
  localparam int NREG = 12, REGW = 16, DEPTH = 32, WAITW = 16, PULSEW = 8;
  localparam int IW = 4, AW = 5, EW = 2 + IW + REGW + WAITW, MAXC = 1200;
  logic CLK = 1'b0;
  logic RST = 1'b1, CFG_WE = 1'b0, START = 1'b0, ABORT = 1'b0, LOOP_EN = 1'b0;
  logic [AW-1:0] CFG_WADDR = '0, LOOP_IDX = '0;
  logic [EW-1:0] CFG_WDATA = '0;
  logic [PULSEW-1:0] PULSE_LEN = '0;
  logic [NREG*REGW-1:0] REG_OUT;
  logic SPI_NARST, SPI_CONFIG, BUSY, DONE, WR_COLL;
  logic [AW-1:0] CUR_IDX;
  logic [EW-1:0] mtbl [DEPTH];
  logic [NREG*REGW-1:0] m_regs, x_regs [MAXC];
  logic [8:0] x_flags [MAXC];
  logic m_done, m_coll;
  int n_vec = 0, n_bad = 0;
  int n, le;
  always #5 CLK = ~CLK;
  spi_plock_cfg_seq #(.NREG(NREG), .REGW(REGW), .DEPTH(DEPTH), .WAITW(WAITW), .PULSEW(PULSEW)) dut (
    .CLK(CLK), .RST(RST), .CFG_WE(CFG_WE), .CFG_WADDR(CFG_WADDR), .CFG_WDATA(CFG_WDATA),
    .START(START), .ABORT(ABORT), .LOOP_EN(LOOP_EN), .LOOP_IDX(LOOP_IDX), .PULSE_LEN(PULSE_LEN),
    .REG_OUT(REG_OUT), .SPI_NARST(SPI_NARST), .SPI_CONFIG(SPI_CONFIG), .BUSY(BUSY), .DONE(DONE),
    .CUR_IDX(CUR_IDX), .WR_COLL(WR_COLL)
  );
  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [EW-1:0] mk(input int op, input int idx, input int val, input int w);
    return {2'(op), IW'(idx), REGW'(val), WAITW'(w)};
  endfunction
  function automatic logic [8:0] flags();
    return {BUSY, DONE, SPI_NARST, SPI_CONFIG, CUR_IDX};
  endfunction
  // schedule: each step occupies FETCH+EXEC (+pulse) (+wait) observation slots after START
  task automatic model(input int plen, input int lp, input int li, output int fin);
    logic [NREG*REGW-1:0] r, nr;
    int c, i, pl, op, ix, w, len;
    r = m_regs;
    c = 1;
    i = 0;
    fin = -1;
    pl = plen == 0 ? 1 : plen;
    while (c < MAXC) begin
      op = int'(mtbl[i][EW-1 -: 2]);
      ix = int'(mtbl[i][WAITW+REGW +: IW]);
      w = int'(mtbl[i][WAITW-1:0]);
      len = op == 3 ? 2 : 2 + ((op == 1 || op == 2) ? pl : 0) + w;
      nr = r;
      if (op == 0 && ix < NREG) nr[ix*REGW +: REGW] = mtbl[i][WAITW +: REGW];
      for (int k = c; k < c + len && k < MAXC; k++) begin
        x_regs[k] = k >= c + 2 ? nr : r;
        x_flags[k] = {1'b1, 1'b0, !(op == 1 && k >= c + 2 && k < c + 2 + pl),
                      op == 2 && k >= c + 2 && k < c + 2 + pl, AW'(i)};
      end
      r = nr;
      c += len;
      if (op != 3 && i != DEPTH - 1) i++;
      else if (lp != 0) i = li;
      else begin
        fin = c;
        for (int k = c; k < MAXC; k++) begin
          x_regs[k] = r;
          x_flags[k] = {1'b0, 1'b1, 1'b1, 1'b0, AW'(0)};
        end
        c = MAXC;
      end
    end
  endtask
  task automatic push(input int cnt);
    for (int a = 0; a < cnt; a++) begin
      CFG_WE = 1'b1;
      CFG_WADDR = AW'(a);
      CFG_WDATA = mtbl[a];
      @(negedge CLK);
    end
    CFG_WE = 1'b0;
  endtask
  task automatic run(input int plen, input int lp, input int li, input int nloop, input int coll,
                     input bit wr0, input logic [EW-1:0] e0);
    int fin, cnt;
    if (wr0) mtbl[0] = e0;
    model(plen, lp, li, fin);
    cnt = lp != 0 ? nloop : fin + 2;
    PULSE_LEN = PULSEW'(plen);
    LOOP_EN = lp != 0;
    LOOP_IDX = AW'(li);
    START = 1'b1;
    CFG_WE = wr0;
    CFG_WADDR = '0;
    CFG_WDATA = e0;
    for (int k = 1; k <= cnt; k++) begin
      @(negedge CLK);
      START = 1'b0;
      CFG_WE = k == coll;
      CFG_WDATA = ~e0;
      chk("flags", 256'(flags()), 256'(x_flags[k]));
      chk("regs", 256'(REG_OUT), 256'(x_regs[k]));
    end
    CFG_WE = 1'b0;
    if (coll > 0) m_coll = 1'b1;
    m_regs = x_regs[cnt];
    m_done = x_flags[cnt][7];
    ABORT = 1'b1;
    @(negedge CLK);
    ABORT = 1'b0;
    chk("abort_flags", 256'(flags()), 256'({1'b0, m_done, 1'b1, 1'b0, AW'(0)}));
    chk("abort_regs", 256'(REG_OUT), 256'(m_regs));
    chk("wr_coll", 256'(WR_COLL), 256'(m_coll));
  endtask
  initial begin
    m_regs = '0;
    m_done = 1'b0;
    m_coll = 1'b0;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    chk("reset_flags", 256'({flags(), WR_COLL}), 256'({1'b0, 1'b0, 1'b1, 1'b0, AW'(0), 1'b0}));
    chk("reset_regs", 256'(REG_OUT), 256'(0));
    mtbl[0] = mk(0, 3, 'h32, 0);
    mtbl[1] = mk(3, 0, 0, 0);
    push(2);
    run(1, 0, 0, 0, 0, 0, '0);
    mtbl[0] = mk(1, 0, 0, 5);
    mtbl[1] = mk(3, 0, 0, 0);
    push(2);
    run(20, 0, 0, 0, 0, 0, '0);
    mtbl[0] = mk(2, 0, 0, 0);
    push(2);
    run(0, 0, 0, 0, 0, 0, '0);
    mtbl[0] = mk(0, 5, 0, 0);
    mtbl[1] = mk(0, 7, 1, 10);
    mtbl[2] = mk(0, 7, 0, 10);
    mtbl[3] = mk(3, 0, 0, 0);
    push(4);
    run(1, 1, 1, 150, 0, 0, '0);
    mtbl[0] = mk(0, 1, 'h1111, 30);
    mtbl[1] = mk(3, 0, 0, 0);
    push(2);
    run(1, 0, 0, 0, 3, 0, '0);
    run(1, 0, 0, 0, 0, 0, '0);
    mtbl[0] = mk(0, 12, 'hBEEF, 0);
    mtbl[1] = mk(0, 15, 'h1234, 2);
    mtbl[2] = mk(3, 0, 0, 0);
    push(3);
    run(1, 0, 0, 0, 0, 0, '0);
    mtbl[0] = mk(0, 2, 'h1234, 1);
    mtbl[1] = mk(3, 0, 0, 0);
    push(2);
    run(1, 0, 0, 0, 0, 1, mk(0, 4, 'h5678, 0));
    for (int a = 0; a < DEPTH; a++) mtbl[a] = mk(0, a % NREG, a * 'h101, a % 3);
    push(DEPTH);
    run(1, 0, 0, 0, 0, 0, '0);
    run(1, 1, 28, 200, 0, 0, '0);
    for (int it = 0; it < 20; it++) begin
      n = int'($urandom_range(1, 8));
      for (int a = 0; a < n; a++)
        mtbl[a] = mk(int'($urandom_range(0, 2)), int'($urandom_range(0, 15)), int'($urandom), int'($urandom_range(0, 6)));
      mtbl[n] = mk(3, 0, 0, int'($urandom_range(0, 9)));
      push(n + 1);
      le = int'($urandom_range(0, 1));
      run(int'($urandom_range(0, 5)), le, int'($urandom_range(0, n)), int'($urandom_range(60, 200)), 0, 0, '0);
    end
    mtbl[0] = mk(1, 0, 0, 0);
    mtbl[1] = mk(3, 0, 0, 0);
    push(2);
    PULSE_LEN = 8'd10;
    LOOP_EN = 1'b0;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    repeat (3) @(negedge CLK);
    chk("narst_mid", 256'(SPI_NARST), 256'(0));
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("rst_flags", 256'({flags(), WR_COLL}), 256'({1'b0, 1'b0, 1'b1, 1'b0, AW'(0), 1'b0}));
    chk("rst_regs", 256'(REG_OUT), 256'(0));
    m_regs = '0;
    m_done = 1'b0;
    m_coll = 1'b0;
    mtbl[0] = mk(0, 9, 'hA5A5, 2);
    mtbl[1] = mk(2, 0, 0, 1);
    mtbl[2] = mk(3, 0, 0, 0);
    push(3);
    run(3, 0, 0, 0, 0, 0, '0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
